// File: rtl/simon_pkg.sv
// -----------------------------------------------------------------------------
// simon_pkg
//   Shared types and helpers for the Simon sequencer.
//   - simon_state_t : engine state encoding (also exported on the debug port)
//   - LFSR_TAPS     : tap mask for the 16-bit Fibonacci LFSR
//   - f_num_w / f_len_w / f_cnt_w : width helpers for parameter-derived buses
// -----------------------------------------------------------------------------
package simon_pkg;

   typedef enum logic [2:0] {
      ST_GEN      = 3'd0,
      ST_PLAY_ON  = 3'd1,
      ST_PLAY_OFF = 3'd2,
      ST_WAIT     = 3'd3,
      ST_OVER     = 3'd4,
      ST_WON      = 3'd5
   } simon_state_t;

   // Polynomial x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form:
   // the feedback bit is the XOR of bits 0,2,3,5 and enters at bit 15.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   // Width of a button value bus (never narrower than one bit).
   function automatic int f_num_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // Width that can hold the values 0..n inclusive.
   function automatic int f_len_w(input int n);
      return (n > 1) ? $clog2(n + 1) : 1;
   endfunction

   // Width of a counter that runs 0..n-1.
   function automatic int f_cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/simon_lfsr.sv
// -----------------------------------------------------------------------------
// simon_lfsr
//   16-bit Fibonacci LFSR used as the random source for new sequence
//   elements. Advances every clock; reloads SEED while reset is low.
//
// Ports
//   clk     in   game clock
//   reset   in   synchronous, active-low; loads SEED
//   o_bits  out  OUT_W low bits of the current LFSR state
// -----------------------------------------------------------------------------
module simon_lfsr
   import simon_pkg::*;
#(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          OUT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   output logic [OUT_W-1:0] o_bits
);

   logic [15:0] r_lfsr;
   logic        w_fb;

   assign w_fb   = ^(r_lfsr & LFSR_TAPS);
   assign o_bits = r_lfsr[OUT_W-1:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_lfsr <= SEED;
      end else begin
         r_lfsr <= {w_fb, r_lfsr[15:1]};
      end
   end

endmodule

// File: rtl/simon_sequencer.sv
// -----------------------------------------------------------------------------
// simon_sequencer
//   Simon game engine. Each round appends one random element to the stored
//   sequence, plays the whole sequence back as timed press pulses, then
//   checks the player's repeat with an inactivity timeout.
//
// Build option
//   SIMON_RETRY_EN : when defined, the first failure in a round replays the
//                    current sequence instead of ending the game; a second
//                    failure in the same round ends it. Undefined: every
//                    failure ends the game.
//
// Ports
//   clk            in   game clock (60 Hz)
//   reset          in   synchronous, active-low; restarts the game
//   player_num     in   player button value, only looked at with the strobe
//   player_pressed in   one-cycle press strobe
//   simon_turn     out  1 while the engine generates / plays back
//   simon_num      out  value being played back
//   simon_pressed  out  playback press active
//   game_over      out  sticky loss flag
//   game_won       out  sticky win flag
//   score          out  number of completed rounds
//   o_dbg_state    out  current FSM state (simon_state_t encoding)
//
// Handshake: player_pressed is a valid-only strobe (there is no ready). It is
// consumed on the cycle it is high if the engine is in WAIT and dropped
// silently in every other state; player_num is qualified by it.
//
// All outputs are registered. simon_turn/simon_pressed/simon_num are decoded
// from the state of the previous cycle, so the first press appears two cycles
// after reset is released (GEN, then the PLAY_ON register). game_over,
// game_won and score are written on the deciding edge itself.
// -----------------------------------------------------------------------------
module simon_sequencer
   import simon_pkg::*;
#(
   parameter int          NUM_BUTTONS = 4,
   parameter int          MAX_LEN     = 32,
   parameter int          TICK_ON     = 30,
   parameter int          TICK_OFF    = 30,
   parameter int          TIMEOUT     = 120,
   parameter logic [15:0] SEED        = 16'hACE1,
   localparam int         NUM_W       = f_num_w(NUM_BUTTONS),
   localparam int         LEN_W       = f_len_w(MAX_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NUM_W-1:0] player_num,
   input  logic             player_pressed,
   output logic             simon_turn,
   output logic [NUM_W-1:0] simon_num,
   output logic             simon_pressed,
   output logic             game_over,
   output logic             game_won,
   output logic [LEN_W-1:0] score,
   output logic [2:0]       o_dbg_state
);

   localparam int IDX_W    = f_cnt_w(MAX_LEN);
   localparam int TICK_MAX = (TICK_ON > TICK_OFF) ? TICK_ON : TICK_OFF;
   localparam int TICK_W   = f_cnt_w(TICK_MAX);
   localparam int TMR_W    = f_cnt_w(TIMEOUT);

   simon_state_t     r_state;
   logic [NUM_W-1:0] r_mem [0:MAX_LEN-1];
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_idx;
   logic [TICK_W-1:0] r_tick;
   logic [TMR_W-1:0] r_timer;
   logic [LEN_W-1:0] r_score;
   logic             r_over;
   logic             r_won;
   logic             r_turn;
   logic             r_pressed;
   logic [NUM_W-1:0] r_num;

   logic [NUM_W-1:0] w_lfsr_bits;
   logic [NUM_W-1:0] w_rnd;
   logic [IDX_W-1:0] w_wr_addr;
   logic [IDX_W-1:0] w_rd_addr;
   logic [NUM_W-1:0] w_cur;
   logic             w_last;
   logic             w_match;
   logic             w_fail;
   logic             w_retry_ok;

   // ---------------------------------------------------------------- random
   simon_lfsr #(
      .SEED  (SEED),
      .OUT_W (NUM_W)
   ) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .o_bits (w_lfsr_bits)
   );

   // Fold out-of-range values back into 0..NUM_BUTTONS-1 (only matters when
   // NUM_BUTTONS is not a power of two).
   always_comb begin
      w_rnd = w_lfsr_bits;
      if (int'(w_lfsr_bits) >= NUM_BUTTONS) begin
         w_rnd = w_lfsr_bits - NUM_W'(NUM_BUTTONS);
      end
   end

   // ---------------------------------------------------------------- memory
   // len never reaches MAX_LEN in GEN (the game is won first), so the
   // truncated write address is always in range.
   assign w_wr_addr = r_len[IDX_W-1:0];
   assign w_rd_addr = r_idx[IDX_W-1:0];
   assign w_cur     = r_mem[w_rd_addr];

   // Contents survive reset on purpose; only len decides what is valid.
   always_ff @(posedge clk) begin
      if (reset && (r_state == ST_GEN)) begin
         r_mem[w_wr_addr] <= w_rnd;
      end
   end

   // ----------------------------------------------------------- decisions
   assign w_last  = (r_idx == (r_len - LEN_W'(1)));
   assign w_match = (player_num == w_cur);

   // A press on the timeout cycle is judged on its value, not as a timeout.
   always_comb begin
      w_fail = 1'b0;
      if (r_state == ST_WAIT) begin
         if (player_pressed) begin
            w_fail = !w_match;
         end else begin
            w_fail = (r_timer == TMR_W'(TIMEOUT - 1));
         end
      end
   end

`ifdef SIMON_RETRY_EN
   logic r_retry;

   // One free replay per round; a fresh round (GEN) grants a new one.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_retry <= 1'b0;
      end else if (r_state == ST_GEN) begin
         r_retry <= 1'b0;
      end else if (w_fail) begin
         r_retry <= 1'b1;
      end
   end

   assign w_retry_ok = !r_retry;
`else
   assign w_retry_ok = 1'b0;
`endif

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= ST_GEN;
         r_len     <= '0;
         r_idx     <= '0;
         r_tick    <= '0;
         r_timer   <= '0;
         r_score   <= '0;
         r_over    <= 1'b0;
         r_won     <= 1'b0;
         r_turn    <= 1'b1;
         r_pressed <= 1'b0;
         r_num     <= '0;
      end else begin
         // Playback outputs follow the state one cycle later.
         r_pressed <= (r_state == ST_PLAY_ON);
         r_turn    <= (r_state != ST_WAIT);
         if (r_state == ST_PLAY_ON) begin
            r_num <= w_cur;
         end

         case (r_state)
            ST_GEN: begin
               r_len   <= r_len + LEN_W'(1);
               r_idx   <= '0;
               r_tick  <= '0;
               r_state <= ST_PLAY_ON;
            end

            ST_PLAY_ON: begin
               if (r_tick == TICK_W'(TICK_ON - 1)) begin
                  r_tick  <= '0;
                  r_state <= ST_PLAY_OFF;
               end else begin
                  r_tick <= r_tick + TICK_W'(1);
               end
            end

            ST_PLAY_OFF: begin
               if (r_tick == TICK_W'(TICK_OFF - 1)) begin
                  r_tick <= '0;
                  if (w_last) begin
                     r_idx   <= '0;
                     r_timer <= '0;
                     r_state <= ST_WAIT;
                  end else begin
                     r_idx   <= r_idx + LEN_W'(1);
                     r_state <= ST_PLAY_ON;
                  end
               end else begin
                  r_tick <= r_tick + TICK_W'(1);
               end
            end

            ST_WAIT: begin
               if (player_pressed && w_match) begin
                  r_timer <= '0;
                  if (w_last) begin
                     r_score <= r_len;
                     if (r_len == LEN_W'(MAX_LEN)) begin
                        r_won   <= 1'b1;
                        r_state <= ST_WON;
                     end else begin
                        r_state <= ST_GEN;
                     end
                  end else begin
                     r_idx <= r_idx + LEN_W'(1);
                  end
               end else if (w_fail) begin
                  if (w_retry_ok) begin
                     // Replay the current sequence without growing it.
                     r_idx   <= '0;
                     r_tick  <= '0;
                     r_state <= ST_PLAY_ON;
                  end else begin
                     r_over  <= 1'b1;
                     r_state <= ST_OVER;
                  end
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end

            ST_OVER: r_state <= ST_OVER;
            ST_WON:  r_state <= ST_WON;

            default: r_state <= ST_GEN;
         endcase
      end
   end

   assign simon_turn    = r_turn;
   assign simon_num     = r_num;
   assign simon_pressed = r_pressed;
   assign game_over     = r_over;
   assign game_won      = r_won;
   assign score         = r_score;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_simon_sequencer.sv
// -----------------------------------------------------------------------------
// tb_simon_sequencer
//   Directed bench for simon_sequencer with NUM_BUTTONS=4, MAX_LEN=3,
//   TICK_ON=2, TICK_OFF=2, TIMEOUT=8. Sequence elements come from a bench-side
//   model of the x^16+x^14+x^13+x^11+1 LFSR seeded with 16'hACE1; the first
//   element is 16'hACE1[1:0] = 1. Every playback the bench expects is pushed
//   into exp_q, and a monitor pops and compares on each rising simon_pressed.
//   Honours SIMON_RETRY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_simon_sequencer;

   localparam logic [15:0] SEED      = 16'hACE1;
   localparam logic [1:0]  FIRST_VAL = 2'd1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] player_num = 2'd0;
   logic       player_pressed = 1'b0;
   logic       simon_turn;
   logic [1:0] simon_num;
   logic       simon_pressed;
   logic       game_over;
   logic       game_won;
   logic [1:0] score;
   logic [2:0] dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [1:0]  exp_q[$];     // playback values still to be seen
   logic [1:0]  exp_seq[$];   // sequence the player must echo
   logic [15:0] m_lfsr;
   logic        prev_pressed = 1'b0;

   simon_sequencer #(
      .NUM_BUTTONS (4),
      .MAX_LEN     (3),
      .TICK_ON     (2),
      .TICK_OFF    (2),
      .TIMEOUT     (8),
      .SEED        (SEED)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .player_num     (player_num),
      .player_pressed (player_pressed),
      .simon_turn     (simon_turn),
      .simon_num      (simon_num),
      .simon_pressed  (simon_pressed),
      .game_over      (game_over),
      .game_won       (game_won),
      .score          (score),
      .o_dbg_state    (dbg_state)
   );

   // ------------------------------------------------------ clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------ LFSR model
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic nb;
      nb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {nb, s[15:1]};
   endfunction

   always @(posedge clk) begin
      m_lfsr <= reset ? lfsr_next(m_lfsr) : SEED;
   end

   // ------------------------------------------------------ checking
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: one pop per playback press.
   always @(negedge clk) begin
      if (simon_pressed === 1'b1 && !prev_pressed) begin
         if (exp_q.size() == 0) begin
            check("unexpected_playback", 32'(simon_num), 32'hFFFF_FFFF);
         end else begin
            check("playback_num", 32'(simon_num), 32'(exp_q.pop_front()));
         end
      end
      prev_pressed = (simon_pressed === 1'b1);
   end

   // ------------------------------------------------------ driver tasks
   // Called at the negedge just before the DUT's GEN edge.
   task automatic next_elem();
      exp_seq.push_back(m_lfsr[1:0]);
      foreach (exp_seq[i]) exp_q.push_back(exp_seq[i]);
   endtask

   task automatic start_game();
      @(negedge clk);
      reset = 1'b0;
      player_pressed = 1'b0;
      exp_q.delete();
      exp_seq.delete();
      @(negedge clk);
      check("rst_turn", 32'(simon_turn), 32'd1);
      check("rst_pressed", 32'(simon_pressed), 32'd0);
      check("rst_over_won", {game_over, game_won}, 32'd0);
      check("rst_score", 32'(score), 32'd0);
      reset = 1'b1;
      next_elem();
   endtask

   task automatic press(input logic [1:0] v);
      player_num = v;
      player_pressed = 1'b1;
      @(negedge clk);
      player_pressed = 1'b0;
   endtask

   task automatic wait_turn(input logic val);
      for (int k = 0; k < 100; k++) begin
         if (simon_turn === val) return;
         @(negedge clk);
      end
      check("wait_turn_timeout", 32'(simon_turn), 32'(val));
   endtask

   task automatic finish_round();
      check("round_score", 32'(score), 32'(exp_seq.size()));
      check("round_not_over", 32'(game_over), 32'd0);
      if (exp_seq.size() < 3) next_elem();
      else check("round_won", 32'(game_won), 32'd1);
   endtask

   task automatic echo_round(input int delay);
      wait_turn(1'b1);
      wait_turn(1'b0);
      for (int i = 0; i < exp_seq.size(); i++) begin
         repeat (delay) @(negedge clk);
         press(exp_seq[i]);
      end
      finish_round();
   endtask

   task automatic check_drained();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
   endtask

   // ------------------------------------------------------ scenarios
   initial begin
      // Game 1: exact first-round timing, then three rounds to a win.
      start_game();                                         // cycle 0
      @(negedge clk);
      check("c1_pressed", 32'(simon_pressed), 32'd0);
      check("c1_turn", 32'(simon_turn), 32'd1);
      @(negedge clk);
      check("c2_pressed", 32'(simon_pressed), 32'd1);
      check("c2_num", 32'(simon_num), 32'(FIRST_VAL));
      @(negedge clk);
      check("c3_pressed", 32'(simon_pressed), 32'd1);
      @(negedge clk);
      check("c4_pressed", 32'(simon_pressed), 32'd0);
      check("c4_turn", 32'(simon_turn), 32'd1);
      repeat (2) @(negedge clk);
      check("c6_turn", 32'(simon_turn), 32'd0);
      check("c6_score", 32'(score), 32'd0);
      press(exp_seq[0]);
      finish_round();
      echo_round(0);
      echo_round(2);
      repeat (2) @(negedge clk);
      check("won_turn", 32'(simon_turn), 32'd1);
      check("won_pressed", 32'(simon_pressed), 32'd0);
      check("won_state", 32'(dbg_state), 32'd5);
      press(2'd0);
      press(2'd3);
      repeat (2) @(negedge clk);
      check("won_sticky", {game_over, game_won}, 32'd1);
      check("won_score", 32'(score), 32'd3);
      check_drained();

      // Game 2: wrong value in round 2.
      start_game();
      echo_round(1);
      wait_turn(1'b1);
      wait_turn(1'b0);
      press(exp_seq[0] + 2'd1);
`ifdef SIMON_RETRY_EN
      check("retry1_no_over", 32'(game_over), 32'd0);
      foreach (exp_seq[i]) exp_q.push_back(exp_seq[i]);
      wait_turn(1'b1);
      wait_turn(1'b0);
      press(exp_seq[0] + 2'd2);
`endif
      check("mismatch_over", 32'(game_over), 32'd1);
      check("mismatch_score", 32'(score), 32'd1);
      check("mismatch_won", 32'(game_won), 32'd0);
      repeat (2) @(negedge clk);
      check("over_turn", 32'(simon_turn), 32'd1);
      check("over_state", 32'(dbg_state), 32'd4);
      check_drained();

      // Game 3: press on the last allowed cycle, then a timeout.
      start_game();
      wait_turn(1'b1);
      wait_turn(1'b0);                                      // timer = 1
      repeat (6) @(negedge clk);                            // timer = 7
      press(exp_seq[0]);
      finish_round();
      wait_turn(1'b1);
      wait_turn(1'b0);
      repeat (6) @(negedge clk);
      check("tmo_edge_not_over", 32'(game_over), 32'd0);
      @(negedge clk);
`ifdef SIMON_RETRY_EN
      check("tmo_retry_no_over", 32'(game_over), 32'd0);
      foreach (exp_seq[i]) exp_q.push_back(exp_seq[i]);
      wait_turn(1'b1);
      wait_turn(1'b0);
      repeat (7) @(negedge clk);
`endif
      check("tmo_over", 32'(game_over), 32'd1);
      check("tmo_score", 32'(score), 32'd1);
      check_drained();

      // Game 4: reset pulse in the middle of round-2 playback.
      start_game();
      echo_round(1);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (simon_pressed === 1'b1) break;
      end
      #1;
      reset = 1'b0;
      exp_q.delete();
      exp_seq.delete();
      @(negedge clk);
      check("midrst_pressed", 32'(simon_pressed), 32'd0);
      check("midrst_turn", 32'(simon_turn), 32'd1);
      check("midrst_num", 32'(simon_num), 32'd0);
      check("midrst_score", 32'(score), 32'd0);
      check("midrst_flags", {game_over, game_won}, 32'd0);
      reset = 1'b1;
      next_elem();
      repeat (2) @(negedge clk);
      check("restart_pressed", 32'(simon_pressed), 32'd1);
      check("restart_num", 32'(simon_num), 32'(FIRST_VAL));
      repeat (4) @(negedge clk);
      check("restart_turn", 32'(simon_turn), 32'd0);
      check_drained();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
